// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one instruction at a time
// over a req/ready/rvalid handshake and presents it pre-split until retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic        next_pc_src,
  input  logic [31:0] alu_res,
  output logic        inst_valid,
  output logic [31:0] Inst,
  output logic [6:0]  OpCode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] PC,
  output logic [31:0] PCInc
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcinc_q;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            req_q;
  logic            valid_q;

  // Next-state, next-PC and instruction capture logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (imem_rvalid) begin
            inst_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          // Branch targets are forced halfword-aligned; no misalignment trap
          pc_d    = next_pc_src ? (alu_res & ~XLEN'(1)) : pcinc_q;
          inst_d  = NOP_INST;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, PC and registered output flags with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      pcinc_q <= RESET_PC + XLEN'(4);
      inst_q  <= NOP_INST;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcinc_q <= pc_d + XLEN'(4);
      inst_q  <= inst_d;
      req_q   <= (state_d == S_FETCH);
      valid_q <= (state_d == S_HOLD);
    end
  end

  // Request is suppressed while reset is held so memory never sees a stale fetch
  assign imem_req   = req_q & rst_n;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign Inst       = inst_q;
  assign OpCode     = inst_q[6:0];
  assign funct3     = inst_q[14:12];
  assign funct7     = inst_q[31:25];
  assign rs1        = inst_q[19:15];
  assign rs2        = inst_q[24:20];
  assign rd         = inst_q[11:7];
  assign PC         = pc_q;
  assign PCInc      = pcinc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences and
// randomized transactions against a PC/instruction reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        retire;
  logic        next_pc_src;
  logic [31:0] alu_res;
  logic        inst_valid;
  logic [31:0] Inst;
  logic [6:0]  OpCode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] PC;
  logic [31:0] PCInc;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .retire(retire), .next_pc_src(next_pc_src), .alu_res(alu_res),
    .inst_valid(inst_valid), .Inst(Inst), .OpCode(OpCode), .funct3(funct3),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .PC(PC), .PCInc(PCInc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;

  typedef struct {
    logic [31:0] w;
    int          r;
    int          d;
    logic        src;
    logic [31:0] alu;
    int          extra;
    logic [31:0] pc;
    logic [31:0] pcinc;
    logic [6:0]  op;
    logic [4:0]  rdx;
    logic [2:0]  f3;
  } vec_t;

  vec_t tab[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rn: 0 quiet, 1 random retire/rvalid noise outside HOLD, 2 retire held high
  task automatic noise(input int rn, input bit allow_rvalid);
    if (rn == 1) begin
      retire      = 1'($urandom_range(1));
      next_pc_src = 1'($urandom_range(1));
      alu_res     = $urandom;
      if (allow_rvalid) begin
        imem_rvalid = 1'($urandom_range(1));
        imem_rdata  = $urandom;
      end
    end else if (rn == 2) begin
      retire = 1'b1;
    end
  endtask

  // Starts in a FETCH cycle, ends in the first HOLD cycle
  task automatic fetch_phase(input logic [31:0] w, input int r, input int d, input int rn);
    chk("req_in_fetch", 32'(imem_req), 32'd1);
    chk("addr_in_fetch", imem_addr, exp_pc);
    chk("valid_in_fetch", 32'(inst_valid), 32'd0);
    chk("nop_in_fetch", Inst, NOP);
    for (int i = 0; i < r; i++) begin
      noise(rn, 1'b1);
      step();
      imem_rvalid = 1'b0;
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, exp_pc);
      chk("valid_before_ready", 32'(inst_valid), 32'd0);
    end
    noise(rn, 1'b0);
    imem_ready  = 1'b1;
    imem_rvalid = (d == 0);
    imem_rdata  = (d == 0) ? w : $urandom;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    for (int i = 1; i <= d; i++) begin
      chk("req_low_in_wait", 32'(imem_req), 32'd0);
      chk("valid_low_in_wait", 32'(inst_valid), 32'd0);
      noise(rn, 1'b0);
      if (i == d) begin
        imem_rvalid = 1'b1;
        imem_rdata  = w;
      end
      step();
      imem_rvalid = 1'b0;
    end
    if (rn != 2) retire = 1'b0;
    chk("valid_in_hold", 32'(inst_valid), 32'd1);
    chk("inst", Inst, w);
    chk("opcode", 32'(OpCode), w & 32'h7f);
    chk("rd", 32'(rd), (w >> 7) & 32'h1f);
    chk("funct3", 32'(funct3), (w >> 12) & 32'h7);
    chk("rs1", 32'(rs1), (w >> 15) & 32'h1f);
    chk("rs2", 32'(rs2), (w >> 20) & 32'h1f);
    chk("funct7", 32'(funct7), w >> 25);
    chk("pc", PC, exp_pc);
    chk("pcinc", PCInc, exp_pc + 32'd4);
  endtask

  // Optional HOLD cycles with spurious rvalid, then the retire edge
  task automatic retire_phase(input logic [31:0] w, input logic src, input logic [31:0] alu,
                              input int extra, input int rn);
    for (int i = 0; i < extra; i++) begin
      retire      = 1'b0;
      imem_rvalid = 1'($urandom_range(1));
      imem_rdata  = $urandom;
      step();
      imem_rvalid = 1'b0;
      chk("inst_frozen", Inst, w);
      chk("valid_stays", 32'(inst_valid), 32'd1);
      chk("pc_frozen", PC, exp_pc);
    end
    retire      = 1'b1;
    next_pc_src = src;
    alu_res     = alu;
    step();
    retire = (rn == 2);
    exp_pc = src ? (alu & 32'hFFFF_FFFE) : exp_pc + 32'd4;
  endtask

  initial begin
    tab[0] = '{32'h0050_0093, 0, 0, 1'b0, 32'h0,         0, 32'h0000_0100, 32'h0000_0104, 7'h13, 5'd1, 3'd0};
    tab[1] = '{32'h0020_8133, 1, 3, 1'b1, 32'h0000_1FFD, 2, 32'h0000_0104, 32'h0000_0108, 7'h33, 5'd2, 3'd0};
    tab[2] = '{32'h0000_006F, 0, 0, 1'b1, 32'h0000_2001, 0, 32'h0000_1FFC, 32'h0000_2000, 7'h6F, 5'd0, 3'd0};
    tab[3] = '{32'h00C5_8463, 2, 1, 1'b1, 32'hFFFF_FFFD, 1, 32'h0000_2000, 32'h0000_2004, 7'h63, 5'd8, 3'd0};
    tab[4] = '{32'h1234_5037, 0, 2, 1'b0, 32'h0,         0, 32'hFFFF_FFFC, 32'h0000_0000, 7'h37, 5'd0, 3'd5};

    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    retire = 1'b0; next_pc_src = 1'b0; alu_res = '0;
    step(); step();
    chk("req_in_reset", 32'(imem_req), 32'd0);
    chk("valid_in_reset", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    exp_pc = RST_PC;
    chk("reset_addr", imem_addr, 32'h0000_0100);
    chk("reset_inst", Inst, 32'h0000_0013);

    // Directed table: alignment clearing, wait states, spurious rvalid, PC wrap
    foreach (tab[k]) begin
      fetch_phase(tab[k].w, tab[k].r, tab[k].d, 0);
      chk("tab_pc", PC, tab[k].pc);
      chk("tab_pcinc", PCInc, tab[k].pcinc);
      chk("tab_opcode", 32'(OpCode), 32'(tab[k].op));
      chk("tab_rd", 32'(rd), 32'(tab[k].rdx));
      chk("tab_funct3", 32'(funct3), 32'(tab[k].f3));
      retire_phase(tab[k].w, tab[k].src, tab[k].alu, tab[k].extra, 0);
    end
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset while in WAIT aborts the transaction
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("req_low_wait_pre_reset", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    step();
    chk("req_low_reset_mid", 32'(imem_req), 32'd0);
    chk("valid_low_reset_mid", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    exp_pc = RST_PC;
    chk("req_after_mid_reset", 32'(imem_req), 32'd1);
    chk("addr_after_mid_reset", imem_addr, RST_PC);
    // Late rvalid without ready in FETCH is ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("late_rvalid_req", 32'(imem_req), 32'd1);
    chk("late_rvalid_valid", 32'(inst_valid), 32'd0);
    chk("late_rvalid_inst", Inst, NOP);

    // Retire held high: one advance per fetched instruction
    retire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = $urandom;
      fetch_phase(w, i % 2, i % 3, 2);
      retire_phase(w, 1'b0, 32'h0, 0, 2);
    end
    retire = 1'b0;
    #1;
    chk("cont_retire_addr", imem_addr, RST_PC + 32'd16);

    // Randomized transactions against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] w;
      logic [31:0] a;
      logic        s;
      w = $urandom;
      a = $urandom;
      s = 1'($urandom_range(1));
      fetch_phase(w, int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(1)));
      retire_phase(w, s, a, int'($urandom_range(2)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
